// File: rtl/invaders_video_scan_if.sv
// Video fetch bus between invaders_video_scan (master) and invaders_memory (slave):
// RAM fetch request/address/data and colour PROM address/data.
interface invaders_video_scan_if;
    logic        Vid_Req;
    logic [15:0] Vid_Addr;
    logic [7:0]  Vid_Data;
    logic [10:0] Color_Prom_Addr;
    logic [7:0]  Color_In;

    modport master (
        output Vid_Req, Vid_Addr, Color_Prom_Addr,
        input  Vid_Data, Color_In
    );

    modport slave (
        input  Vid_Req, Vid_Addr, Color_Prom_Addr,
        output Vid_Data, Color_In
    );
endinterface

// File: rtl/invaders_video_scan.sv
// Raster timing, per-group VRAM/colour fetch and pixel serialiser for a 256x224 bitmap.
// Optional INVADERS_VIDEO_FLIP_EN adds a Flip input that mirrors the picture in both axes.
module invaders_video_scan #(
    parameter int unsigned H_TOTAL      = 320,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned HS_START     = 272,
    parameter int unsigned HS_END       = 304,
    parameter int unsigned V_TOTAL      = 262,
    parameter int unsigned V_ACTIVE     = 224,
    parameter int unsigned VS_START     = 236,
    parameter int unsigned VS_END       = 239,
    parameter logic [15:0] VRAM_BASE    = 16'h2400,
    parameter int unsigned IRQ_MID_LINE = 96
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Ce_pix,
    input  logic Color_Mode,
`ifdef INVADERS_VIDEO_FLIP_EN
    input  logic Flip,
`endif
    invaders_video_scan_if.master bus,
    output logic Pix_R,
    output logic Pix_G,
    output logic Pix_B,
    output logic Hblank,
    output logic Vblank,
    output logic Hsync,
    output logic Vsync,
    output logic Irq_Mid,
    output logic Irq_End
);

    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned G_TOTAL = H_TOTAL / 8;
    localparam int unsigned G_W     = ($clog2(G_TOTAL + 1) > 6) ? $clog2(G_TOTAL + 1) : 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic [1:0]     state, state_nxt;
    logic           req_nxt, fetch_start_c, fetch_skip_c, capture_c;
    logic [7:0]     hold_data, shifter;
    logic [2:0]     hold_color, shift_color;
    logic           vid_req;
    logic [15:0]    vid_addr;
    logic [10:0]    prom_addr;
    logic           flip_c;

`ifdef INVADERS_VIDEO_FLIP_EN
    assign flip_c = Flip;
`else
    assign flip_c = 1'b0;
`endif

    // Fetch target: next group, and the next line when the group index wraps
    logic [G_W-1:0] grp_c, g_c;
    logic [V_W-1:0] vt_c, row_c;
    logic [4:0]     col_c;
    logic           fetch_ok_c;
    logic [15:0]    addr_c;

    always_comb begin
        grp_c      = G_W'(h >> 3);
        g_c        = (grp_c == G_W'(G_TOTAL - 1)) ? '0 : grp_c + G_W'(1);
        vt_c       = v;
        if (g_c == '0) begin
            vt_c = (v == V_W'(V_TOTAL - 1)) ? '0 : v + V_W'(1);
        end
        fetch_ok_c = (g_c < G_W'(32)) && (vt_c < V_W'(V_ACTIVE));
        row_c      = flip_c ? V_W'(V_ACTIVE - 1) - vt_c : vt_c;
        col_c      = flip_c ? 5'd31 - g_c[4:0] : g_c[4:0];
        addr_c     = VRAM_BASE + (16'(row_c) << 5) + 16'(col_c);
    end

    // Fetch FSM: state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch FSM: next state and control strobes
    always_comb begin
        state_nxt     = state;
        req_nxt       = 1'b0;
        fetch_start_c = 1'b0;
        fetch_skip_c  = 1'b0;
        capture_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Ce_pix && (h[2:0] == 3'd6)) begin
                    if (fetch_ok_c) begin
                        state_nxt     = ST_ADDR;
                        req_nxt       = 1'b1;
                        fetch_start_c = 1'b1;
                    end else begin
                        fetch_skip_c = 1'b1;
                    end
                end
            end
            ST_ADDR: state_nxt = ST_CAPT;
            ST_CAPT: begin
                capture_c = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture may coincide with the group-load Ce_pix, so bypass the holding register then
    logic [7:0] load_data_c, load_bits_c;
    logic [2:0] load_color_c;
    logic       blank_c, pix_c;

    always_comb begin
        load_data_c  = capture_c ? bus.Vid_Data : hold_data;
        load_color_c = capture_c ? bus.Color_In[2:0] : hold_color;
        load_bits_c  = flip_c ? {<<{load_data_c}} : load_data_c;
        blank_c      = (h >= H_W'(H_ACTIVE)) || (v >= V_W'(V_ACTIVE));
        pix_c        = shifter[0] && !blank_c;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            h           <= '0;
            v           <= '0;
            vid_req     <= 1'b0;
            vid_addr    <= '0;
            prom_addr   <= '0;
            hold_data   <= '0;
            hold_color  <= '0;
            shifter     <= '0;
            shift_color <= '0;
            Pix_R       <= 1'b0;
            Pix_G       <= 1'b0;
            Pix_B       <= 1'b0;
            Hblank      <= 1'b0;
            Vblank      <= 1'b0;
            Hsync       <= 1'b0;
            Vsync       <= 1'b0;
            Irq_Mid     <= 1'b0;
            Irq_End     <= 1'b0;
        end else begin
            vid_req <= req_nxt;
            Irq_Mid <= Ce_pix && (h == '0) && (v == V_W'(IRQ_MID_LINE));
            Irq_End <= Ce_pix && (h == '0) && (v == V_W'(V_ACTIVE));
            if (fetch_start_c) begin
                vid_addr  <= addr_c;
                prom_addr <= {addr_c[12:7], addr_c[4:0]};
            end
            if (fetch_skip_c) begin
                hold_data  <= '0;
                hold_color <= '0;
            end else if (capture_c) begin
                hold_data  <= bus.Vid_Data;
                hold_color <= bus.Color_In[2:0];
            end
            if (Ce_pix) begin
                Pix_R  <= pix_c && (!Color_Mode || shift_color[0]);
                Pix_G  <= pix_c && (!Color_Mode || shift_color[2]);
                Pix_B  <= pix_c && (!Color_Mode || shift_color[1]);
                Hblank <= h >= H_W'(H_ACTIVE);
                Vblank <= v >= V_W'(V_ACTIVE);
                Hsync  <= (h >= H_W'(HS_START)) && (h < H_W'(HS_END));
                Vsync  <= (v >= V_W'(VS_START)) && (v < V_W'(VS_END));
                if (h[2:0] == 3'd7) begin
                    shifter     <= load_bits_c;
                    shift_color <= load_color_c;
                end else begin
                    shifter <= shifter >> 1;
                end
                if (h == H_W'(H_TOTAL - 1)) begin
                    h <= '0;
                    v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + V_W'(1);
                end else begin
                    h <= h + H_W'(1);
                end
            end
        end
    end

    assign bus.Vid_Req         = vid_req;
    assign bus.Vid_Addr        = vid_addr;
    assign bus.Color_Prom_Addr = prom_addr;

endmodule

// File: tb/tb_invaders_video_scan.sv
// Directed bench: a full-size scanner for address/timing/IRQ checks and a
// reduced-geometry scanner to reach frame-boundary, pixel and Irq_End checks quickly.
module tb_invaders_video_scan;

    logic clk;
    logic rst_n;
    logic ce;
    logic color_mode;
    logic flip;

    logic m_r, m_g, m_b, m_hb, m_vb, m_hs, m_vs, m_im, m_ie;
    logic s_r, s_g, s_b, s_hb, s_vb, s_hs, s_vs, s_im, s_ie;

    logic [7:0] ram  [0:65535];
    logic [7:0] prom [0:2047];

    invaders_video_scan_if bus_m ();
    invaders_video_scan_if bus_s ();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM / PROM reads, as the memory block does
    always @(posedge clk) begin
        bus_m.Vid_Data <= ram[bus_m.Vid_Addr];
        bus_m.Color_In <= prom[bus_m.Color_Prom_Addr];
        bus_s.Vid_Data <= ram[bus_s.Vid_Addr];
        bus_s.Color_In <= prom[bus_s.Color_Prom_Addr];
    end

    invaders_video_scan dut_m (
        .Clock      (clk),
        .Reset_n    (rst_n),
        .Ce_pix     (ce),
        .Color_Mode (color_mode),
`ifdef INVADERS_VIDEO_FLIP_EN
        .Flip       (flip),
`endif
        .bus        (bus_m),
        .Pix_R      (m_r),
        .Pix_G      (m_g),
        .Pix_B      (m_b),
        .Hblank     (m_hb),
        .Vblank     (m_vb),
        .Hsync      (m_hs),
        .Vsync      (m_vs),
        .Irq_Mid    (m_im),
        .Irq_End    (m_ie)
    );

    invaders_video_scan #(
        .H_TOTAL      (64),
        .H_ACTIVE     (32),
        .HS_START     (40),
        .HS_END       (48),
        .V_TOTAL      (16),
        .V_ACTIVE     (8),
        .VS_START     (10),
        .VS_END       (12),
        .IRQ_MID_LINE (4)
    ) dut_s (
        .Clock      (clk),
        .Reset_n    (rst_n),
        .Ce_pix     (ce),
        .Color_Mode (color_mode),
`ifdef INVADERS_VIDEO_FLIP_EN
        .Flip       (flip),
`endif
        .bus        (bus_s),
        .Pix_R      (s_r),
        .Pix_G      (s_g),
        .Pix_B      (s_b),
        .Hblank     (s_hb),
        .Vblank     (s_vb),
        .Hsync      (s_hs),
        .Vsync      (s_vs),
        .Irq_Mid    (s_im),
        .Irq_End    (s_ie)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ce_pulse();
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    localparam int N_END = 96 * 320 + 2;

    initial begin
        int mh, mv, sh, sf;
        int line4_req, blank_req, ie_cnt, mid_first;

        line4_req  = 0;
        blank_req  = 0;
        ie_cnt     = 0;
        mid_first  = -1;
        rst_n      = 1'b0;
        ce         = 1'b0;
        color_mode = 1'b0;
        flip       = 1'b0;
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        for (int a = 0; a < 2048; a++) prom[a] = 8'h00;
        ram[16'h2400]  = 8'h81;
        ram[16'h2401]  = 8'hFF;
        prom[11'h101]  = 8'h04;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Run into the first fetch of the line, then reset while it is in flight
        for (int k = 0; k < 7; k++) begin
            ce_pulse();
            if (k < 6) begin
                @(posedge clk);
                #1;
            end
        end
        check("pre_rst_req", bus_m.Vid_Req, 1);
        rst_n = 1'b0;
        #1;
        check("rst_req", bus_m.Vid_Req, 0);
        check("rst_addr", bus_m.Vid_Addr, 16'h0000);
        check("rst_prom", bus_m.Color_Prom_Addr, 11'h000);
        check("rst_flags_m", {m_hb, m_vb, m_hs, m_vs, m_im, m_ie, m_r, m_g, m_b}, 0);
        check("rst_flags_s", {s_hb, s_vb, s_hs, s_vs, s_im, s_ie, s_r, s_g, s_b}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_req", bus_m.Vid_Req, 0);
        end
        check("post_rst_addr", bus_m.Vid_Addr, 16'h0000);

        for (int n = 0; n <= N_END; n++) begin
            color_mode = (n >= 1032);
            ce_pulse();
            mh = n % 320;
            mv = n / 320;
            sh = n % 64;
            sf = n / 1024;

            // Full-size scanner, sampled just after the Ce_pix edge
            if (n == 4 * 320 + 318) begin
                check("pref5_req", bus_m.Vid_Req, 1);
                check("pref5_addr", bus_m.Vid_Addr, 16'h24A0);
                check("pref5_prom", bus_m.Color_Prom_Addr, {6'h09, 5'h00});
            end
            if (mv == 4 && bus_m.Vid_Req) begin
                line4_req++;
                if (mh >= 254 && mh <= 310) blank_req++;
            end
            if (mv == 4 && mh == 255) check("hblank_255", m_hb, 0);
            if (mv == 4 && mh == 256) begin
                check("hblank_256", m_hb, 1);
                check("pix_256", {m_r, m_g, m_b}, 3'b000);
            end
            if (mv == 4 && mh == 319) check("hblank_319", m_hb, 1);
            if (mv == 4 && mh == 271) check("hsync_271", m_hs, 0);
            if (mv == 4 && mh == 272) check("hsync_272", m_hs, 1);
            if (mv == 4 && mh == 303) check("hsync_303", m_hs, 1);
            if (mv == 4 && mh == 304) check("hsync_304", m_hs, 0);
            if (m_im && mid_first < 0) mid_first = n;

            // Reduced scanner: frame-boundary prefetch, IRQs, sync, pixels
            if (n == 15 * 64 + 62) begin
                check("wrap_req", bus_s.Vid_Req, 1);
                check("wrap_addr", bus_s.Vid_Addr, 16'h2400);
                check("wrap_prom", bus_s.Color_Prom_Addr, 11'h100);
            end
            if (sf == 0 && s_ie) ie_cnt++;
            if (n == 256) check("s_irq_mid", s_im, 1);
            if (n == 511) check("s_vblank_511", s_vb, 0);
            if (n == 512) begin
                check("s_irq_end", s_ie, 1);
                check("s_vblank_512", s_vb, 1);
            end
            if (n == 639) check("s_vsync_639", s_vs, 0);
            if (n == 640) check("s_vsync_640", s_vs, 1);
            if (n == 768) check("s_vsync_768", s_vs, 0);
            if (n == 1024) check("s_hblank_0", s_hb, 0);
            if (n >= 1024 && n < 1032)
                check($sformatf("mono_h%0d", sh), {s_r, s_g, s_b},
                      (sh == 0 || sh == 7) ? 3'b111 : 3'b000);
            if (n >= 1032 && n < 1040)
                check($sformatf("color_h%0d", sh), {s_r, s_g, s_b}, 3'b010);

            @(posedge clk);
            #1;
            // One clock later: pulses and the request must have dropped
            if (n == 4 * 320 + 318) check("pref5_req_drop", bus_m.Vid_Req, 0);
            if (mv == 4 && bus_m.Vid_Req) line4_req++;
            if (sf == 0 && s_ie) ie_cnt++;
            if (n == 96 * 320) check("irq_mid_drop", m_im, 0);
        end

        check("line4_req_count", line4_req, 32);
        check("blank_req_count", blank_req, 0);
        check("irq_end_pulses", ie_cnt, 1);
        check("irq_mid_first", mid_first, 96 * 320);

`ifdef INVADERS_VIDEO_FLIP_EN
        rst_n = 1'b0;
        flip  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ce_pulse();
            if (k < 6) begin
                @(posedge clk);
                #1;
            end
        end
        check("flip_addr", bus_m.Vid_Addr, 16'h3FFE);
        check("flip_prom", bus_m.Color_Prom_Addr, {6'h3F, 5'h1E});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
